// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared 3-bit code decoder,
// dwell/guard digit sequencing and a double-buffered, tear-free code register.
module seg7_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DWELL_CYCLES = 1000,
   parameter int unsigned GUARD_CYCLES = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      load,
   input  logic [3*NUM_DIGITS-1:0]   codes_in,
   output logic                      load_ack,
   output logic [0:6]                segmentcode,
   output logic [NUM_DIGITS-1:0]     digit_sel,
   output logic                      frame_done
);

   localparam int unsigned MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CODE_W  = 3 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GUARD = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CODE_W-1:0]       pending_q, pending_d;
   logic [CODE_W-1:0]       active_q, active_d;
   logic                    dirty_q, dirty_d;
   logic                    load_ack_q, load_ack_d;
   logic                    frame_done_q, frame_done_d;
   logic [0:6]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic                    commit;
   logic [2:0]              cur_code;

   // Codes 0-3 render as digits, anything else renders the 'E' glyph.
   function automatic logic [0:6] decode(input logic [2:0] code);
      logic [0:6] seg;
      case (code)
         3'd0:    seg = 7'b1111110;
         3'd1:    seg = 7'b0110000;
         3'd2:    seg = 7'b1101101;
         3'd3:    seg = 7'b1111001;
         default: seg = 7'b1001111;
      endcase
      return seg;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         pending_q    <= '0;
         active_q     <= '0;
         dirty_q      <= 1'b0;
         load_ack_q   <= 1'b0;
         frame_done_q <= 1'b0;
         seg_q        <= '0;
         sel_q        <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         active_q     <= active_d;
         dirty_q      <= dirty_d;
         load_ack_q   <= load_ack_d;
         frame_done_q <= frame_done_d;
         seg_q        <= seg_d;
         sel_q        <= sel_d;
      end
   end

   // Next-state, buffer handshake and registered-output preparation.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      pending_d    = pending_q;
      active_d     = active_q;
      dirty_d      = dirty_q;
      load_ack_d   = load;
      frame_done_d = 1'b0;
      seg_d        = '0;
      sel_d        = '0;
      commit       = 1'b0;
      cur_code     = 3'd0;

      case (state_q)
         ST_IDLE: begin
            commit = dirty_q;
            if (enable) begin
               state_d = ST_DRIVE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == DWELL_LAST) begin
               state_d = ST_GUARD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d        = '0;
                  frame_done_d = 1'b1;
                  commit       = dirty_q;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
               if (enable) begin
                  state_d = ST_DRIVE;
               end else begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase

      // Commit consumes the old pending value; a same-cycle load stays pending.
      if (commit) begin
         active_d = pending_q;
         dirty_d  = 1'b0;
      end
      if (load) begin
         pending_d = codes_in;
         dirty_d   = 1'b1;
      end

      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == idx_d) begin
            cur_code = active_d[3*i +: 3];
         end
      end

      if (state_d == ST_DRIVE) begin
         sel_d = NUM_DIGITS'(1) << idx_d;
         seg_d = decode(cur_code);
      end
   end

   assign load_ack    = load_ack_q;
   assign frame_done  = frame_done_q;
   assign segmentcode = seg_q;
   assign digit_sel   = sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized and directed bench for seg7_scan_ctrl against a frame-position reference model.
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int D     = 4;
   localparam int G     = 2;
   localparam int SLOT  = D + G;
   localparam int FRAME = N * SLOT;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic             load;
   logic [3*N-1:0]   codes_in;
   logic             load_ack;
   logic [0:6]       segmentcode;
   logic [N-1:0]     digit_sel;
   logic             frame_done;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: a single position counter inside the frame.
   bit  m_run;
   int  m_pos;
   int  m_pend[N];
   int  m_act[N];
   bit  m_dirty;
   bit  e_ack;
   bit  e_fd;

   logic [6:0] seg_tab[5];

   seg7_scan_ctrl #(
      .NUM_DIGITS  (N),
      .DWELL_CYCLES(D),
      .GUARD_CYCLES(G)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .codes_in   (codes_in),
      .load_ack   (load_ack),
      .segmentcode(segmentcode),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run   = 1'b0;
      m_pos   = 0;
      m_dirty = 1'b0;
      e_ack   = 1'b0;
      e_fd    = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0;
         m_act[i]  = 0;
      end
   endtask

   task automatic model_edge();
      bit commit;
      commit = 1'b0;
      e_ack  = load;
      e_fd   = 1'b0;
      if (!m_run) begin
         commit = m_dirty;
         if (enable) begin
            m_run = 1'b1;
            m_pos = 0;
         end
      end else begin
         m_pos++;
         if (m_pos % SLOT == 0) begin
            if (m_pos == FRAME) begin
               m_pos  = 0;
               e_fd   = 1'b1;
               commit = m_dirty;
            end
            if (!enable) begin
               m_run = 1'b0;
               m_pos = 0;
            end
         end
      end
      if (commit) begin
         m_act   = m_pend;
         m_dirty = 1'b0;
      end
      if (load) begin
         for (int i = 0; i < N; i++) m_pend[i] = int'(codes_in[3*i +: 3]);
         m_dirty = 1'b1;
      end
   endtask

   task automatic check_outputs();
      logic [31:0] exp_sel;
      logic [31:0] exp_seg;
      int d;
      exp_sel = 0;
      exp_seg = 0;
      if (m_run && (m_pos % SLOT) < D) begin
         d       = m_pos / SLOT;
         exp_sel = 32'(1) << d;
         exp_seg = 32'(seg_tab[(m_act[d] < 4) ? m_act[d] : 4]);
      end
      chk("digit_sel", 32'(digit_sel), exp_sel);
      chk("segmentcode", 32'(segmentcode), exp_seg);
      chk("load_ack", 32'(load_ack), 32'(e_ack));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("onehot", 32'($countones(digit_sel) <= 1), 32'd1);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_load(input logic [3*N-1:0] c);
      codes_in = c;
      load     = 1'b1;
      step();
      load     = 1'b0;
      codes_in = 12'($urandom);
   endtask

   // Advance until the model sits at frame position p while scanning.
   task automatic run_to_pos(input string tag, input int p);
      int k;
      k = 0;
      while (!(m_run && m_pos == p) && k < 200) begin
         step();
         k++;
      end
      chk(tag, 32'(m_run && m_pos == p), 32'd1);
   endtask

   initial begin
      seg_tab[0] = 7'b1111110;
      seg_tab[1] = 7'b0110000;
      seg_tab[2] = 7'b1101101;
      seg_tab[3] = 7'b1111001;
      seg_tab[4] = 7'b1001111;

      rst_n    = 1'b0;
      enable   = 1'b0;
      load     = 1'b0;
      codes_in = '0;
      model_reset();
      #12;
      chk("rst_sel", 32'(digit_sel), 32'd0);
      chk("rst_seg", 32'(segmentcode), 32'd0);
      chk("rst_ack", 32'(load_ack), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(3);

      // Scan of {3,2,1,0}, committed while idle.
      do_load({3'd3, 3'd2, 3'd1, 3'd0});
      step();
      enable = 1'b1;
      run(2 * FRAME + 4);

      // Error glyph for codes 4..7.
      do_load({3'd7, 3'd6, 3'd5, 3'd4});
      run(2 * FRAME);

      // Tear-free update mid-frame.
      do_load({3'd3, 3'd2, 3'd1, 3'd0});
      run_to_pos("reach_mid", 8);
      do_load({3'd1, 3'd0, 3'd0, 3'd0});
      run(2 * FRAME);

      // Load coinciding with the frame-boundary commit.
      do_load({3'd2, 3'd2, 3'd2, 3'd2});
      run_to_pos("reach_end", FRAME - 1);
      do_load({3'd1, 3'd1, 3'd1, 3'd1});
      run(3 * FRAME);

      // Stop mid-DRIVE of digit 2, then restart.
      run_to_pos("reach_d2", 2 * SLOT + 1);
      enable = 1'b0;
      run(20);
      enable = 1'b1;
      run(FRAME + 3);

      // Asynchronous reset mid-DRIVE.
      run_to_pos("reach_rst", SLOT + 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sel", 32'(digit_sel), 32'd0);
      chk("arst_seg", 32'(segmentcode), 32'd0);
      chk("arst_ack", 32'(load_ack), 32'd0);
      chk("arst_fd", 32'(frame_done), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("restart_sel", 32'(digit_sel), 32'd1);
      run(FRAME);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         enable   = ($urandom_range(0, 99) < 93);
         load     = ($urandom_range(0, 11) == 0);
         codes_in = 12'($urandom);
         step();
      end
      load = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
